// File: rtl/jesd_tx_pkg.sv
// Shared types and constants for the JESD204B single-lane transmit link.
// Imported by the link sequencer and its ILAS lookup.
package jesd_tx_pkg;

  typedef enum logic [1:0] {
    CGS  = 2'd0,
    ILAS = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;

  localparam int ILAS_MF    = 4;
  localparam int CFG_OCTETS = 14;

endpackage

// File: rtl/jesd_tx_ilas_gen.sv
// ILAS octet lookup: (multiframe, position, link config) -> (octet, k).
// Purely combinational; the caller feeds next-cycle mf/position.
import jesd_tx_pkg::*;

module jesd_tx_ilas_gen #(
  parameter int K = 32
) (
  input  logic [1:0]              i_mf,
  input  logic [4:0]              i_p,
  input  logic [8*CFG_OCTETS-1:0] i_cfg,
  output logic [7:0]              o_octet,
  output logic                    o_k
);

  logic [6:0] w_off;
  logic       w_cfg;
  logic       w_q;

  assign w_off = {i_p[3:0] - 4'd2, 3'b000};
  assign w_q   = (i_mf == 2'd1) && (i_p == 5'd1);
  assign w_cfg = (i_mf == 2'd1)
              && (i_p >= 5'd2)
              && (i_p <= 5'd15);

  always_comb begin
    o_octet = {3'b000, i_p};
    o_k     = 1'b0;
    unique case (1'b1)
      (i_p == 5'd0): begin
        o_octet = K28_0;
        o_k     = 1'b1;
      end
      (i_p == 5'(K-1)): begin
        o_octet = K28_3;
        o_k     = 1'b1;
      end
      w_q: begin
        o_octet = K28_4;
        o_k     = 1'b1;
      end
      w_cfg: begin
        o_octet = i_cfg[w_off +: 8];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/jesd_tx_link.sv
// JESD204B single-lane transmit link sequencer (CGS -> ILAS -> DATA).
// Outputs are computed from the next state and registered.
import jesd_tx_pkg::*;

module jesd_tx_link #(
  parameter int K          = 32,
  parameter int RESYNC_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sync_n,
  input  logic [8*CFG_OCTETS-1:0] cfg_octets,
  input  logic                    upstream_val,
  output logic                    upstream_rdy,
  input  logic [7:0]              upstream_dat,
  output logic [7:0]              tx_dat,
  output logic                    tx_k,
  output logic                    lmfc_pulse,
  output logic                    link_up,
  output logic                    underflow,
  input  logic                    underflow_clr
);

  localparam int LW = $clog2(RESYNC_CYC);
  localparam logic [4:0]    LMFC_LAST = 5'(K-1);
  localparam logic [LW-1:0] LOW_MAX   = LW'(RESYNC_CYC-1);
  localparam logic [1:0]    MF_LAST   = 2'(ILAS_MF-1);

  state_t        r_state;
  state_t        w_next;
  logic [4:0]    r_lmfc;
  logic [4:0]    w_lmfc_nxt;
  logic [1:0]    r_mf;
  logic [1:0]    w_mf_nxt;
  logic [LW-1:0] r_low;
  logic          w_lmfc_end;
  logic          w_resync;
  logic [7:0]    w_ilas_dat;
  logic          w_ilas_k;
  logic [7:0]    w_dat_nxt;
  logic          w_k_nxt;

  assign w_lmfc_end = (r_lmfc == LMFC_LAST);
  assign w_lmfc_nxt = w_lmfc_end ? 5'd0 : r_lmfc + 5'd1;

  // Only a sustained low SYNC~ restarts; short pulses are error reports.
  assign w_resync = (r_state != CGS)
                 && !sync_n
                 && (r_low == LOW_MAX);

  assign lmfc_pulse = (r_lmfc == 5'd0);
  assign link_up    = (r_state == DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CGS;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CGS: begin
        if (sync_n && w_lmfc_end) w_next = ILAS;
      end
      ILAS: begin
        if (w_resync) w_next = CGS;
        else if ((r_mf == MF_LAST) && w_lmfc_end) w_next = DATA;
      end
      DATA: begin
        if (w_resync) w_next = CGS;
      end
      default: w_next = CGS;
    endcase
  end

  always_comb begin
    if ((r_state == ILAS) && (w_next == ILAS) && w_lmfc_end) begin
      w_mf_nxt = r_mf + 2'd1;
    end else if (w_next == ILAS) begin
      w_mf_nxt = r_mf;
    end else begin
      w_mf_nxt = 2'd0;
    end
  end

  jesd_tx_ilas_gen #(
    .K(K)
  ) u_ilas (
    .i_mf   (w_mf_nxt),
    .i_p    (w_lmfc_nxt),
    .i_cfg  (cfg_octets),
    .o_octet(w_ilas_dat),
    .o_k    (w_ilas_k)
  );

  always_comb begin
    upstream_rdy = (w_next == DATA);
    w_dat_nxt    = K28_5;
    w_k_nxt      = 1'b1;
    unique case (w_next)
      ILAS: begin
        w_dat_nxt = w_ilas_dat;
        w_k_nxt   = w_ilas_k;
      end
      DATA: begin
        w_dat_nxt = upstream_val ? upstream_dat : 8'h00;
        w_k_nxt   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lmfc <= 5'd0;
      r_mf   <= 2'd0;
      r_low  <= '0;
    end else begin
      r_lmfc <= w_lmfc_nxt;
      r_mf   <= w_mf_nxt;
      if (sync_n) r_low <= '0;
      else if (r_low != LOW_MAX) r_low <= r_low + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_dat    <= K28_5;
      tx_k      <= 1'b1;
      underflow <= 1'b0;
    end else begin
      tx_dat <= w_dat_nxt;
      tx_k   <= w_k_nxt;
      if (upstream_rdy && !upstream_val) underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jesd_tx_link.sv
// Bench for jesd_tx_link: cycle-by-cycle compare against a
// sequence-level model, plus literal anchor checks.
module tb_jesd_tx_link;
  localparam int K  = 32;
  localparam int RC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sync_n = 1'b0;
  logic [111:0] cfg_octets;
  logic         upstream_val = 1'b0;
  logic         upstream_rdy;
  logic [7:0]   upstream_dat = 8'h00;
  logic [7:0]   tx_dat;
  logic         tx_k;
  logic         lmfc_pulse;
  logic         link_up;
  logic         underflow;
  logic         underflow_clr = 1'b0;

  always #5 clk = ~clk;

  jesd_tx_link #(.K(K), .RESYNC_CYC(RC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_n       (sync_n),
    .cfg_octets   (cfg_octets),
    .upstream_val (upstream_val),
    .upstream_rdy (upstream_rdy),
    .upstream_dat (upstream_dat),
    .tx_dat       (tx_dat),
    .tx_k         (tx_k),
    .lmfc_pulse   (lmfc_pulse),
    .link_up      (link_up),
    .underflow    (underflow),
    .underflow_clr(underflow_clr)
  );

  int n_chk = 0;
  int n_pass = 0;

  // model: cycles since reset, phase (0 cgs,1 ilas,2 data), ILAS octet index
  int         m_cnt;
  int         m_mode;
  int         m_i;
  int         m_low;
  bit         m_uf;
  logic [7:0] m_dat;
  bit         m_k;
  bit         m_rdy;
  bit         last_xfer;
  logic [7:0] ramp = 8'h00;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic void ilas_octet(input int i, output logic [7:0] o,
                                     output bit k);
    int mf = i / K;
    int p  = i % K;
    o = p[7:0];
    k = 1'b0;
    if (p == 0) begin
      o = 8'h1C; k = 1'b1;
    end else if (p == K-1) begin
      o = 8'h7C; k = 1'b1;
    end else if (mf == 1 && p == 1) begin
      o = 8'h9C; k = 1'b1;
    end else if (mf == 1 && p >= 2 && p <= 15) begin
      o = cfg_octets[8*(p-2) +: 8];
    end
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_mode = 0; m_i = 0; m_low = 0; m_uf = 1'b0;
    m_dat = 8'hBC; m_k = 1'b1;
  endtask

  function automatic bit model_resync();
    return (m_mode != 0) && !sync_n && (m_low + 1 >= RC);
  endfunction

  task automatic model_pre();
    m_rdy = !model_resync() &&
            (m_mode == 2 || (m_mode == 1 && m_i == 4*K-1));
  endtask

  task automatic data_out(inout bit set);
    m_k = 1'b0;
    if (upstream_val) m_dat = upstream_dat;
    else begin
      m_dat = 8'h00;
      set = 1'b1;
    end
  endtask

  task automatic model_edge();
    int lm = m_cnt % K;
    bit set = 1'b0;
    if (model_resync()) begin
      m_mode = 0; m_dat = 8'hBC; m_k = 1'b1;
    end else if (m_mode == 0) begin
      if (sync_n && lm == K-1) begin
        m_mode = 1; m_i = 0;
        ilas_octet(0, m_dat, m_k);
      end else begin
        m_dat = 8'hBC; m_k = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (m_i == 4*K-1) begin
        m_mode = 2;
        data_out(set);
      end else begin
        m_i++;
        ilas_octet(m_i, m_dat, m_k);
      end
    end else begin
      data_out(set);
    end
    if (set) m_uf = 1'b1;
    else if (underflow_clr) m_uf = 1'b0;
    m_low = sync_n ? 0 : m_low + 1;
    m_cnt++;
  endtask

  task automatic check_all();
    chk("tx_dat", tx_dat, m_dat);
    chk("tx_k", tx_k, m_k);
    chk("lmfc_pulse", lmfc_pulse, (m_cnt % K) == 0);
    chk("link_up", link_up, m_mode == 2);
    chk("underflow", underflow, m_uf);
  endtask

  // entered #1 after a posedge; leaves #1 after the next posedge
  task automatic step(input logic s, input logic v,
                      input logic [7:0] d, input logic c);
    sync_n = s; upstream_val = v; upstream_dat = d; underflow_clr = c;
    #1;
    model_pre();
    chk("upstream_rdy", upstream_rdy, m_rdy);
    last_xfer = m_rdy && v;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_dat"}, tx_dat, 8'hBC);
    chk({tag, "_tx_k"}, tx_k, 1);
    chk({tag, "_lmfc_pulse"}, lmfc_pulse, 1);
    chk({tag, "_link_up"}, link_up, 0);
    chk({tag, "_underflow"}, underflow, 0);
    chk({tag, "_rdy"}, upstream_rdy, 0);
  endtask

  initial begin
    int pulses;
    int guard;
    bit found;
    for (int i = 0; i < 14; i++) cfg_octets[8*i +: 8] = 8'(8'hA0 + i);
    model_reset();
    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // CGS held by sync_n low
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 8'h00, 0);
      if (lmfc_pulse) pulses++;
    end
    chk("cgs_pulse_count", 8'(pulses), 8'd3);

    guard = 0;
    while ((m_cnt % K) != 5 && guard < 64) begin
      step(0, 0, 8'h00, 0);
      guard++;
    end

    // sync_n rises at lmfc 5; ILAS then DATA with a ramp
    for (int n = 1; n <= 160; n++) begin
      step(1, 1, ramp, 0);
      if (last_xfer) ramp++;
      if (n == 26)  chk("cgs_last", tx_dat, 8'hBC);
      if (n == 27)  chk("ilas_first_R", tx_dat, 8'h1C);
      if (n == 58)  chk("mf0_A", tx_dat, 8'h7C);
      if (n == 60)  chk("mf1_Q", tx_dat, 8'h9C);
      if (n == 61)  chk("mf1_cfg0", tx_dat, 8'hA0);
      if (n == 74)  chk("mf1_cfg13", tx_dat, 8'hAD);
      if (n == 154) chk("ilas_last_link", link_up, 0);
      if (n == 155) chk("link_up_rise", link_up, 1);
      if (n == 155) chk("data_first", tx_dat, 8'h00);
      if (n == 156) chk("data_second", tx_dat, 8'h01);
    end
    repeat (300) begin
      step(1, 1, ramp, 0);
      if (last_xfer) ramp++;
    end

    // underflow set / hold / clear / set-wins
    step(1, 0, ramp, 0);
    chk("uf_dat", tx_dat, 8'h00);
    chk("uf_set", underflow, 1);
    step(1, 1, ramp, 0); if (last_xfer) ramp++;
    chk("uf_hold", underflow, 1);
    step(1, 1, ramp, 1); if (last_xfer) ramp++;
    chk("uf_clr", underflow, 0);
    step(1, 0, ramp, 1);
    chk("uf_set_wins", underflow, 1);
    step(1, 1, ramp, 1); if (last_xfer) ramp++;

    for (int i = 0; i < 300; i++) begin
      step(1, $urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 7) == 0);
    end

    // short low is ignored, four lows resync
    repeat (3) step(0, 1, 8'($urandom), 0);
    step(1, 1, 8'($urandom), 0);
    chk("short_low_link", link_up, 1);
    repeat (3) step(0, 1, 8'($urandom), 0);
    sync_n = 1'b0;
    #1;
    chk("resync_rdy_4th", upstream_rdy, 0);
    step(0, 1, 8'($urandom), 0);
    chk("resync_cgs", tx_dat, 8'hBC);
    chk("resync_link", link_up, 0);
    repeat (20) step(0, 1, 8'($urandom), 0);
    repeat (200) step(1, 1, 8'($urandom), 0);
    chk("relink", link_up, 1);

    // glitchy SYNC~ with periodic long lows
    for (int i = 0; i < 600; i++) begin
      step((i % 150 >= 140) ? 1'b0 : ($urandom_range(0, 5) != 0),
           $urandom_range(0, 4) != 0, 8'($urandom),
           $urandom_range(0, 9) == 0);
    end

    // async reset in mf2 of ILAS
    repeat (5) step(0, 1, 8'($urandom), 0);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(1, 1, 8'($urandom), 0);
      if (m_mode == 1 && m_i == 2*K+5) found = 1'b1;
    end
    chk("reach_mf2", found, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("async_rst");
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", tx_dat, 8'hBC);
    rst_n = 1'b1;
    model_reset();
    step(0, 1, 8'h00, 0);
    chk("restart_lmfc1", lmfc_pulse, 0);
    repeat (30) step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    chk("restart_lmfc0", lmfc_pulse, 1);
    repeat (200) step(1, 1, 8'($urandom), 0);
    chk("final_link", link_up, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
